// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and default vectors for the 6502 interrupt/BRK/reset entry sequencer.
// Latency: n/a (types, constants and a vector-select helper only).
// Backpressure: n/a. Ports: none.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DUMMY,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_P,
    VEC_LO,
    VEC_HI
  } int_seq_state_t;

  typedef enum logic [1:0] {
    SRC_RESET,
    SRC_NMI,
    SRC_BRK,
    SRC_IRQ
  } int_src_t;

  // Low-byte vector addresses; the high byte is always at base+1.
  localparam logic [15:0] DEF_VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] DEF_VEC_RESET = 16'hFFFC;
  localparam logic [15:0] DEF_VEC_IRQ   = 16'hFFFE;

  // BRK shares the IRQ vector; the B bit in the pushed P tells them apart.
  function automatic logic [15:0] vec_base(input int_src_t   src,
                                           input logic [15:0] vec_nmi,
                                           input logic [15:0] vec_reset,
                                           input logic [15:0] vec_irq);
    case (src)
      SRC_NMI:   return vec_nmi;
      SRC_RESET: return vec_reset;
      default:   return vec_irq;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Decoder-side bundle of the interrupt sequencer: request inputs, RDY and all sequencer outputs.
// Latency: n/a (wiring only). Backpressure: RDY travels here, toward the sequencer.
// Ports: master = decoder/CPU side, drives requests; slave = sequencer, drives DB selects and address controls.
interface interrupt_sequencer_if;

  logic        Start;
  logic        Reset_Req;
  logic        NMI_Pending;
  logic        IRQ_Line;
  logic        I_Flag;
  logic        BRK_Op;
  logic        RDY;

  logic        PCH_DB;
  logic        PCL_DB;
  logic        P_DB;
  logic        DL_DB;
  logic        B_Flag;
  logic        Write;
  logic        SP_Dec;
  logic        Addr_Stack;
  logic        Addr_Vector;
  logic [15:0] Vector_Addr;
  logic        Set_I;
  logic        NMI_Ack;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, Reset_Req, NMI_Pending, IRQ_Line, I_Flag, BRK_Op, RDY,
    input  PCH_DB, PCL_DB, P_DB, DL_DB, B_Flag, Write, SP_Dec, Addr_Stack,
           Addr_Vector, Vector_Addr, Set_I, NMI_Ack, Busy, Done
  );

  modport slave (
    input  Start, Reset_Req, NMI_Pending, IRQ_Line, I_Flag, BRK_Op, RDY,
    output PCH_DB, PCL_DB, P_DB, DL_DB, B_Flag, Write, SP_Dec, Addr_Stack,
           Addr_Vector, Vector_Addr, Set_I, NMI_Ack, Busy, Done
  );

endinterface

// File: rtl/interrupt_sequencer_prio.sv
// Picks the interrupt source: Reset_Req > NMI_Pending > BRK_Op > unmasked IRQ, with a valid flag.
// Latency: purely combinational. Backpressure: none.
// Ports: reset_req, nmi_pending, brk_op, irq_line, i_flag in; src (int_src_t) and vld out.
module int_priority_encoder
  import cpu_pkg::*;
(
  input  logic     reset_req,
  input  logic     nmi_pending,
  input  logic     brk_op,
  input  logic     irq_line,
  input  logic     i_flag,
  output int_src_t src,
  output logic     vld
);

  always_comb begin
    src = SRC_RESET;
    vld = 1'b1;
    if (reset_req)                 src = SRC_RESET;
    else if (nmi_pending)          src = SRC_NMI;
    else if (brk_op)               src = SRC_BRK;
    else if (irq_line && !i_flag)  src = SRC_IRQ;
    else                           vld = 1'b0;
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/BRK/reset entry sequencer: dummy read, push PCH/PCL/P, fetch vector lo/hi.
// Latency: 6 cycles from the accepting Start edge; Busy in all six, Done on the last.
// Backpressure: RDY low holds DUMMY/VEC_LO/VEC_HI; pushes ignore RDY.
// Ports: clk, rst (async active-high), bus (interrupt_sequencer_if.slave).
// Option: define INT_SEQ_NMI_HIJACK_EN to let a pending NMI take over a BRK/IRQ after the P push.
module interrupt_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] VEC_NMI   = DEF_VEC_NMI,
  parameter logic [15:0] VEC_RESET = DEF_VEC_RESET,
  parameter logic [15:0] VEC_IRQ   = DEF_VEC_IRQ
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_sequencer_if.slave  bus
);

  int_seq_state_t state, state_nxt;
  int_src_t       src, src_nxt;
  int_src_t       enc_src;
  logic           enc_vld;
  logic [15:0]    base;

  int_priority_encoder u_prio (
    .reset_req   (bus.Reset_Req),
    .nmi_pending (bus.NMI_Pending),
    .brk_op      (bus.BRK_Op),
    .irq_line    (bus.IRQ_Line),
    .i_flag      (bus.I_Flag),
    .src         (enc_src),
    .vld         (enc_vld)
  );

  // src resets to RESET so the vector base is never undefined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      src   <= SRC_RESET;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    case (state)
      IDLE: begin
        if (bus.Start && enc_vld) begin
          state_nxt = DUMMY;
          src_nxt   = enc_src;
        end
      end
      DUMMY:    if (bus.RDY) state_nxt = PUSH_PCH;
      PUSH_PCH: state_nxt = PUSH_PCL;
      PUSH_PCL: state_nxt = PUSH_P;
      PUSH_P: begin
        state_nxt = VEC_LO;
`ifdef INT_SEQ_NMI_HIJACK_EN
        // P is already on the stack with its B bit; only the vector changes.
        if ((src == SRC_BRK || src == SRC_IRQ) && bus.NMI_Pending)
          src_nxt = SRC_NMI;
`endif
      end
      VEC_LO:   if (bus.RDY) state_nxt = VEC_HI;
      VEC_HI:   if (bus.RDY) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign base = vec_base(src, VEC_NMI, VEC_RESET, VEC_IRQ);

  // Outputs decode state/src only; RDY gates the three pulses so they fire once.
  always_comb begin
    bus.PCH_DB      = 1'b0;
    bus.PCL_DB      = 1'b0;
    bus.P_DB        = 1'b0;
    bus.DL_DB       = 1'b0;
    bus.B_Flag      = 1'b0;
    bus.Write       = 1'b0;
    bus.SP_Dec      = 1'b0;
    bus.Addr_Stack  = 1'b0;
    bus.Addr_Vector = 1'b0;
    bus.Vector_Addr = 16'h0000;
    bus.Set_I       = 1'b0;
    bus.NMI_Ack     = 1'b0;
    bus.Busy        = (state != IDLE);
    bus.Done        = 1'b0;
    case (state)
      PUSH_PCH, PUSH_PCL, PUSH_P: begin
        bus.PCH_DB     = (state == PUSH_PCH);
        bus.PCL_DB     = (state == PUSH_PCL);
        bus.P_DB       = (state == PUSH_P);
        bus.B_Flag     = (state == PUSH_P) && (src == SRC_BRK);
        // Reset walks SP down with reads so the stack is left untouched.
        bus.Write      = (src != SRC_RESET);
        bus.SP_Dec     = 1'b1;
        bus.Addr_Stack = 1'b1;
      end
      VEC_LO: begin
        bus.Addr_Vector = 1'b1;
        bus.Vector_Addr = base;
        bus.Set_I       = bus.RDY;
        bus.NMI_Ack     = bus.RDY && (src == SRC_NMI);
      end
      VEC_HI: begin
        bus.DL_DB       = 1'b1;
        bus.Addr_Vector = 1'b1;
        bus.Vector_Addr = base + 16'd1;
        bus.Done        = bus.RDY;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: reset/BRK/NMI/IRQ sequences, RDY stall, hijack, abort.
// Latency: n/a. Backpressure: RDY driven directly.
// Ports: none (top-level bench).
module tb_interrupt_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  interrupt_sequencer_if bus ();

  interrupt_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Output word: {PCH,PCL,P,DL,B,WR,SPD,AS,AV,SI,NA,BZ,DN}
  localparam logic [12:0] PCH = 13'h1000, PCL = 13'h0800, PB = 13'h0400, DL = 13'h0200;
  localparam logic [12:0] BF  = 13'h0100, WR  = 13'h0080, SPD = 13'h0040, AS = 13'h0020;
  localparam logic [12:0] AV  = 13'h0010, SI  = 13'h0008, NA  = 13'h0004, BZ = 13'h0002;
  localparam logic [12:0] DN  = 13'h0001;
  localparam logic [12:0] PUSH = BZ | SPD | AS;

  function automatic logic [12:0] obs();
    return {bus.PCH_DB, bus.PCL_DB, bus.P_DB, bus.DL_DB, bus.B_Flag, bus.Write,
            bus.SP_Dec, bus.Addr_Stack, bus.Addr_Vector, bus.Set_I, bus.NMI_Ack,
            bus.Busy, bus.Done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input string tag, input logic [12:0] e, input logic [15:0] va);
    logic [12:0] o;
    o = obs();
    n_total += 1;
    assert (o === e) n_pass += 1;
    else begin n_fail += 1; $error("FAIL %s outs got %h want %h", tag, o, e); end
    n_total += 1;
    assert (bus.Vector_Addr === va) n_pass += 1;
    else begin n_fail += 1; $error("FAIL %s vec got %h want %h", tag, bus.Vector_Addr, va); end
    n_total += 1;
    assert (($countones(o[12:9]) <= 1) === 1'b1) n_pass += 1;
    else begin n_fail += 1; $error("FAIL %s onehot got %b want <=1 set", tag, o[12:9]); end
  endtask

  initial begin
    rst = 1'b1;
    bus.Start = 0; bus.Reset_Req = 0; bus.NMI_Pending = 0; bus.IRQ_Line = 0;
    bus.I_Flag = 0; bus.BRK_Op = 0; bus.RDY = 1;
    #3;
    cyc("por", 13'h0, 16'h0);
    @(negedge clk); rst = 1'b0;
    tick();
    cyc("idle", 13'h0, 16'h0);

    // Reset source; a Start+NMI while busy must be ignored.
    bus.Reset_Req = 1; bus.Start = 1;
    tick(); bus.Start = 0; bus.Reset_Req = 0;
    cyc("rst_c1", BZ, 16'h0);
    bus.Start = 1; bus.NMI_Pending = 1;
    tick(); bus.Start = 0; bus.NMI_Pending = 0;
    cyc("rst_c2", PUSH | PCH, 16'h0);
    tick(); cyc("rst_c3", PUSH | PCL, 16'h0);
    tick(); cyc("rst_c4", PUSH | PB, 16'h0);
    tick(); cyc("rst_c5", BZ | AV | SI, 16'hFFFC);
    tick(); cyc("rst_c6", BZ | AV | DL | DN, 16'hFFFD);
    tick(); cyc("rst_end", 13'h0, 16'h0);

    // BRK
    bus.BRK_Op = 1; bus.Start = 1;
    tick(); bus.Start = 0; bus.BRK_Op = 0;
    cyc("brk_c1", BZ, 16'h0);
    tick(); cyc("brk_c2", PUSH | WR | PCH, 16'h0);
    tick(); cyc("brk_c3", PUSH | WR | PCL, 16'h0);
    tick(); cyc("brk_c4", PUSH | WR | PB | BF, 16'h0);
    tick(); cyc("brk_c5", BZ | AV | SI, 16'hFFFE);
    tick(); cyc("brk_c6", BZ | AV | DL | DN, 16'hFFFF);
    tick(); cyc("brk_end", 13'h0, 16'h0);

    // NMI outranks BRK and IRQ
    bus.NMI_Pending = 1; bus.BRK_Op = 1; bus.IRQ_Line = 1; bus.Start = 1;
    tick(); bus.Start = 0; bus.NMI_Pending = 0; bus.BRK_Op = 0; bus.IRQ_Line = 0;
    cyc("nmi_c1", BZ, 16'h0);
    tick(); cyc("nmi_c2", PUSH | WR | PCH, 16'h0);
    tick(); cyc("nmi_c3", PUSH | WR | PCL, 16'h0);
    tick(); cyc("nmi_c4", PUSH | WR | PB, 16'h0);
    tick(); cyc("nmi_c5", BZ | AV | SI | NA, 16'hFFFA);
    tick(); cyc("nmi_c6", BZ | AV | DL | DN, 16'hFFFB);
    tick(); cyc("nmi_end", 13'h0, 16'h0);

    // Masked IRQ is ignored
    bus.IRQ_Line = 1; bus.I_Flag = 1; bus.Start = 1;
    tick(); cyc("mask_c1", 13'h0, 16'h0);
    tick(); bus.Start = 0;
    cyc("mask_c2", 13'h0, 16'h0);

    // Unmasked IRQ with RDY low in PUSH_PCH (no stall) and 3 stalled VEC_LO cycles
    bus.I_Flag = 0; bus.Start = 1;
    tick(); bus.Start = 0; bus.IRQ_Line = 0;
    cyc("irq_c1", BZ, 16'h0);
    tick(); bus.RDY = 0;
    cyc("irq_c2", PUSH | WR | PCH, 16'h0);
    tick(); cyc("irq_c3", PUSH | WR | PCL, 16'h0);
    tick(); cyc("irq_c4", PUSH | WR | PB, 16'h0);
    tick(); cyc("irq_stall1", BZ | AV, 16'hFFFE);
    tick(); cyc("irq_stall2", BZ | AV, 16'hFFFE);
    tick(); cyc("irq_stall3", BZ | AV, 16'hFFFE);
    bus.RDY = 1; #1;
    cyc("irq_release", BZ | AV | SI, 16'hFFFE);
    tick(); cyc("irq_c6", BZ | AV | DL | DN, 16'hFFFF);
    tick(); cyc("irq_end", 13'h0, 16'h0);

    // NMI arrives during PUSH_PCL of a BRK
    bus.BRK_Op = 1; bus.Start = 1;
    tick(); bus.Start = 0; bus.BRK_Op = 0;
    cyc("hj_c1", BZ, 16'h0);
    tick(); cyc("hj_c2", PUSH | WR | PCH, 16'h0);
    tick(); bus.NMI_Pending = 1;
    cyc("hj_c3", PUSH | WR | PCL, 16'h0);
    tick(); cyc("hj_c4", PUSH | WR | PB | BF, 16'h0);
    tick();
`ifdef INT_SEQ_NMI_HIJACK_EN
    cyc("hj_c5", BZ | AV | SI | NA, 16'hFFFA);
    tick(); cyc("hj_c6", BZ | AV | DL | DN, 16'hFFFB);
`else
    cyc("hj_c5", BZ | AV | SI, 16'hFFFE);
    tick(); cyc("hj_c6", BZ | AV | DL | DN, 16'hFFFF);
`endif
    bus.NMI_Pending = 0;
    tick(); cyc("hj_end", 13'h0, 16'h0);

    // Async abort during PUSH_PCL
    bus.BRK_Op = 1; bus.Start = 1;
    tick(); bus.Start = 0; bus.BRK_Op = 0;
    cyc("ab_c1", BZ, 16'h0);
    tick(); cyc("ab_c2", PUSH | WR | PCH, 16'h0);
    tick(); cyc("ab_c3", PUSH | WR | PCL, 16'h0);
    rst = 1; #1;
    cyc("ab_rst", 13'h0, 16'h0);
    @(negedge clk); rst = 0;
    tick(); cyc("ab_idle", 13'h0, 16'h0);

    // Start accepted normally after abort
    bus.IRQ_Line = 1; bus.Start = 1;
    tick(); bus.Start = 0; bus.IRQ_Line = 0;
    cyc("post_c1", BZ, 16'h0);
    tick(); cyc("post_c2", PUSH | WR | PCH, 16'h0);
    tick(); cyc("post_c3", PUSH | WR | PCL, 16'h0);
    tick(); cyc("post_c4", PUSH | WR | PB, 16'h0);
    tick(); cyc("post_c5", BZ | AV | SI, 16'hFFFE);
    tick(); cyc("post_c6", BZ | AV | DL | DN, 16'hFFFF);
    tick(); cyc("post_end", 13'h0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sequences the CPU internal data bus (DB) and the address path for the 6502 interrupt, BRK and reset entry sequence.
- Drives the one-hot DB source selects PCH_DB, PCL_DB, P_DB and DL_DB for the data bus mux, plus stack pointer and vector addressing controls.
- Sits beside the instruction decoder and is started at an instruction boundary.
- Guarantees at most one DB select is active in any cycle.

Parameters:
- VEC_NMI, 16'hFFFA, NMI vector low-byte address
- VEC_RESET, 16'hFFFC, reset vector low-byte address
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- clk  in  1  CPU clock
- rst  in  1  asynchronous active-high reset
- Start  in  1  single-cycle pulse from the decoder at an instruction boundary
- Reset_Req  in  1  pending reset
- NMI_Pending  in  1  latched NMI edge
- IRQ_Line  in  1  level IRQ
- I_Flag  in  1  processor interrupt-disable flag
- BRK_Op  in  1  current opcode is BRK
- RDY  in  1  external ready; low stalls read cycles only
- PCH_DB, PCL_DB, P_DB, DL_DB  out  1 each  DB source selects, one-hot or all zero
- B_Flag  out  1  bit 4 value for the pushed P
- Write  out  1  bus write strobe
- SP_Dec  out  1  decrement stack pointer this cycle
- Addr_Stack  out  1  address bus = 0x01:SP
- Addr_Vector  out  1  address bus = Vector_Addr
- Vector_Addr  out  16  current vector byte address
- Set_I  out  1  set I flag pulse
- NMI_Ack  out  1  clears the NMI edge latch
- Busy  out  1  sequence in progress
- Done  out  1  pulse on the final cycle

Behaviour:
- Reset (async): state returns to IDLE. All outputs read 0, except the internal source register, which resets to RESET so Vector_Addr's latch is defined. Asserting rst mid-sequence aborts immediately; no partial push completes.
- Source priority, evaluated on the edge where Start=1 in IDLE: Reset_Req > NMI_Pending > BRK_Op > (IRQ_Line & !I_Flag).
  - If no source qualifies, Start is ignored and the block stays in IDLE with no Busy and no Done.
  - The chosen source is latched.
- States: IDLE -> DUMMY -> PUSH_PCH -> PUSH_PCL -> PUSH_P -> VEC_LO -> VEC_HI -> IDLE. This is a 6-cycle sequence; Busy=1 in every non-IDLE state.
- DUMMY: read cycle with no DB select.
- PUSH_PCH / PUSH_PCL / PUSH_P:
  - Assert PCH_DB / PCL_DB / P_DB respectively, together with Addr_Stack=1 and SP_Dec=1.
  - Write=1 unless the source is RESET; reset performs reads with the same SP decrements.
- B_Flag=1 only when the source is BRK; it is valid in PUSH_P.
- VEC_LO:
  - DL_DB=0, Addr_Vector=1, Vector_Addr=base.
  - Set_I=1.
  - NMI_Ack=1 if the source is NMI.
- VEC_HI: DL_DB=1 (loads PCL from the latched low byte), Addr_Vector=1, Vector_Addr=base+1, Done=1.
- Vector base is chosen by source: NMI -> VEC_NMI, RESET -> VEC_RESET, BRK/IRQ -> VEC_IRQ.
- RDY:
  - When low in DUMMY, VEC_LO or VEC_HI, the state holds and all outputs hold. Set_I, NMI_Ack and Done are asserted only on the advancing cycle.
  - RDY is ignored in the PUSH states.
- Start while Busy is ignored.
- Outputs are decoded from the registered state and source only; no combinational path from inputs to outputs except the RDY qualification of the pulse outputs.

Optional Feature:
- Macro INT_SEQ_NMI_HIJACK_EN.
- Defined: if the source is BRK or IRQ and NMI_Pending=1 at the edge leaving PUSH_P, the source becomes NMI. The vector becomes VEC_NMI and NMI_Ack is pulsed in VEC_LO. B_Flag for the already-pushed P keeps its BRK value.
- Undefined: the source is fixed from Start to the end of the sequence, and a pending NMI waits for the next boundary.

Decomposition:
- Package cpu_pkg holds:
  - the int_seq_state_t enum (IDLE, DUMMY, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI)
  - the int_src_t enum (SRC_RESET, SRC_NMI, SRC_BRK, SRC_IRQ)
  - default vector localparams shared with the address generator
- Sub-module int_priority_encoder (purely combinational): source selection plus a valid flag. The FSM stays in the top module.

Test Plan:
- Reset source: Start with Reset_Req=1, RDY=1 -> Busy for 6 cycles. Write=0 throughout; SP_Dec=1 in cycles 2-4; Vector_Addr FFFC then FFFD; Done in cycle 6; at most one DB select per cycle.
- BRK: Start with BRK_Op=1 -> PCH_DB, PCL_DB, P_DB each with Write=1 in cycles 2-4; B_Flag=1 in PUSH_P; Vector_Addr FFFE/FFFF; Set_I in VEC_LO.
- Masked IRQ: IRQ_Line=1, I_Flag=1, Start -> Busy stays 0 and no select asserts. With I_Flag=0 -> full IRQ sequence with B_Flag=0.
- RDY stall: RDY=0 for 3 cycles in VEC_LO -> Vector_Addr holds FFFE and Set_I pulses once on release. RDY=0 in PUSH_PCH -> no stall.
- Hijack: BRK start, NMI_Pending rises during PUSH_PCL. With the macro -> Vector_Addr FFFA, NMI_Ack pulse. Without -> FFFE, no NMI_Ack.
- Abort: rst asserted during PUSH_PCL -> all outputs 0 in the same cycle; after release IDLE and Start is accepted normally.
